// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types and constants for the KSA and keystream stages
package rc4_pkg;

    // S-box RAM depth (one byte per entry)
    localparam int RAM_DEPTH = 256;

    // Default number of secret-key bytes
    localparam int KEY_LEN = 3;

    // Key-scheduling FSM states; each loop iteration walks RD_I..WR_J once
    typedef enum logic [3:0] {
        KSA_IDLE = 4'd0,
        KSA_RD_I = 4'd1,
        KSA_WT_I = 4'd2,
        KSA_LD_I = 4'd3,
        KSA_WT_J = 4'd4,
        KSA_LD_J = 4'd5,
        KSA_WR_I = 4'd6,
        KSA_WR_J = 4'd7,
        KSA_DONE = 4'd8
    } ksa_state_t;

    // Width of an index that counts 0..n-1 (at least one bit)
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/key_byte_sel.sv
// rtl/key_byte_sel.sv - selects secret-key byte idx, byte 0 being the MSB byte
module key_byte_sel #(
    parameter int KEY_LEN = 3,
    parameter int KEY_W   = 8 * KEY_LEN,
    parameter int IDX_W   = 2
) (
    input  logic [KEY_W-1:0] key_i,
    input  logic [IDX_W-1:0] idx_i,
    output logic [7:0]       byte_o
);

    // Plain mux over the key bytes; out-of-range indices yield zero
    always_comb begin
        byte_o = 8'h00;
        for (int k = 0; k < KEY_LEN; k++) begin
            if (idx_i == IDX_W'(k)) begin
                byte_o = key_i[KEY_W-1-8*k -: 8];
            end
        end
    end

endmodule

// File: rtl/ksa_swap_fsm.sv
// rtl/ksa_swap_fsm.sv - RC4 key-scheduling swap loop over a shared single-port S-box RAM (option: KSA_KEY_LATCH_EN)
module ksa_swap_fsm #(
    parameter int KEY_LEN = rc4_pkg::KEY_LEN,
    parameter int KEY_W   = 8 * KEY_LEN
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] secret_key,
    input  logic [7:0]       q,
    output logic [7:0]       address,
    output logic [7:0]       data,
    output logic             wren,
    output logic             busy,
    output logic             done
);

    import rc4_pkg::*;

    localparam int          IDX_W  = idx_width(KEY_LEN);
    localparam logic [7:0]  LAST_I = 8'(RAM_DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_K = IDX_W'(KEY_LEN - 1);

    ksa_state_t       state_q;
    logic [7:0]       i_q;
    logic [7:0]       j_q;
    logic [7:0]       si_q;
    logic [7:0]       sj_q;
    logic [IDX_W-1:0] kidx_q;       // i mod KEY_LEN, kept as a wrap counter
    logic [7:0]       address_q;
    logic [7:0]       data_q;
    logic             wren_q;
    logic             busy_q;
    logic             done_q;

    logic [KEY_W-1:0] key_src;
    logic [7:0]       key_byte;
    logic [7:0]       j_d;

`ifdef KSA_KEY_LATCH_EN
    logic [KEY_W-1:0] key_q;

    // Capture the key as the run is accepted so later key changes cannot disturb it
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_q <= '0;
        end else if (state_q == KSA_IDLE && start) begin
            key_q <= secret_key;
        end
    end

    assign key_src = key_q;
`else
    // Key is consumed live; the upstream holds it stable for the whole run
    assign key_src = secret_key;
`endif

    key_byte_sel #(
        .KEY_LEN (KEY_LEN),
        .KEY_W   (KEY_W),
        .IDX_W   (IDX_W)
    ) u_key_byte_sel (
        .key_i  (key_src),
        .idx_i  (kidx_q),
        .byte_o (key_byte)
    );

    // New j uses S[i] straight off the RAM read port (q is valid in WT_I -> LD_I)
    assign j_d = j_q + q + key_byte;

    // Swap-loop FSM; all RAM-side outputs are registered on state entry
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= KSA_IDLE;
            i_q       <= 8'h00;
            j_q       <= 8'h00;
            si_q      <= 8'h00;
            sj_q      <= 8'h00;
            kidx_q    <= '0;
            address_q <= 8'h00;
            data_q    <= 8'h00;
            wren_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                KSA_IDLE: begin
                    wren_q <= 1'b0;
                    if (start) begin
                        state_q   <= KSA_RD_I;
                        busy_q    <= 1'b1;
                        address_q <= i_q;
                    end
                end
                KSA_RD_I: begin
                    state_q <= KSA_WT_I;
                end
                KSA_WT_I: begin
                    // Read of S[i] lands now; launch the read of S[j]
                    state_q   <= KSA_LD_I;
                    si_q      <= q;
                    j_q       <= j_d;
                    address_q <= j_d;
                end
                KSA_LD_I: begin
                    state_q <= KSA_WT_J;
                end
                KSA_WT_J: begin
                    state_q <= KSA_LD_J;
                    sj_q    <= q;
                end
                KSA_LD_J: begin
                    state_q   <= KSA_WR_I;
                    address_q <= i_q;
                    data_q    <= sj_q;
                    wren_q    <= 1'b1;
                end
                KSA_WR_I: begin
                    // When i == j this second write overwrites the first with si,
                    // which leaves the entry as it was
                    state_q   <= KSA_WR_J;
                    address_q <= j_q;
                    data_q    <= si_q;
                    wren_q    <= 1'b1;
                end
                KSA_WR_J: begin
                    wren_q <= 1'b0;
                    if (i_q == LAST_I) begin
                        state_q   <= KSA_DONE;
                        address_q <= 8'h00;
                        busy_q    <= 1'b0;
                        done_q    <= 1'b1;
                    end else begin
                        state_q   <= KSA_RD_I;
                        i_q       <= i_q + 8'd1;
                        address_q <= i_q + 8'd1;
                        kidx_q    <= (kidx_q == LAST_K) ? '0 : kidx_q + IDX_W'(1);
                    end
                end
                KSA_DONE: begin
                    wren_q    <= 1'b0;
                    address_q <= 8'h00;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                end
                default: begin
                    state_q <= KSA_IDLE;
                    wren_q  <= 1'b0;
                end
            endcase
        end
    end

    assign address = address_q;
    assign data    = data_q;
    assign wren    = wren_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_ksa_swap_fsm.sv
// tb/tb_ksa_swap_fsm.sv - self-checking bench for ksa_swap_fsm against a golden RC4 KSA model
module tb_ksa_swap_fsm;

    logic        clk;
    logic        reset;
    logic        start;
    logic [23:0] secret_key;
    logic [7:0]  q;
    logic [7:0]  address;
    logic [7:0]  data;
    logic        wren;
    logic        busy;
    logic        done;

    int n_total;
    int n_pass;

    logic [7:0] mem  [0:255];
    logic [7:0] gold [0:255];
    logic [7:0] addr_r;
    logic       init_req;

    logic [7:0] wr_addr [0:8191];
    logic [7:0] wr_data [0:8191];
    int         wr_cnt;

    ksa_swap_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .secret_key (secret_key),
        .q          (q),
        .address    (address),
        .data       (data),
        .wren       (wren),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM: registers address/data/wren on the edge, read data from registered address
    always @(posedge clk) begin
        if (init_req) begin
            for (int k = 0; k < 256; k++) mem[k] <= 8'(k);
        end else if (wren) begin
            mem[address] <= data;
            wr_addr[wr_cnt[12:0]] <= address;
            wr_data[wr_cnt[12:0]] <= data;
            wr_cnt <= wr_cnt + 1;
        end
        addr_r <= address;
    end
    assign q = mem[addr_r];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic init_ram();
        @(negedge clk) init_req = 1'b1;
        @(negedge clk) init_req = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
    endtask

    // Textbook RC4 key schedule on an array
    task automatic compute_gold(input logic [23:0] key);
        logic [7:0] jj, t, kb;
        for (int k = 0; k < 256; k++) gold[k] = 8'(k);
        jj = 8'h00;
        for (int ii = 0; ii < 256; ii++) begin
            kb = key[23 - 8*(ii % 3) -: 8];
            jj = jj + gold[ii] + kb;
            t = gold[ii];
            gold[ii] = gold[jj];
            gold[jj] = t;
        end
    endtask

    task automatic check_ram(input string tag);
        int bad;
        bad = 0;
        for (int k = 0; k < 256; k++) if (mem[k] !== gold[k]) bad++;
        check(tag, 32'(bad), 32'd0);
    endtask

    task automatic check_wr(input string tag, input int idx, input logic [7:0] ea, input logic [7:0] ed);
        check({tag, "_addr"}, {24'd0, wr_addr[idx[12:0]]}, {24'd0, ea});
        check({tag, "_data"}, {24'd0, wr_data[idx[12:0]]}, {24'd0, ed});
    endtask

    // One full run from an identity RAM; returns the write-log index of its first write
    task automatic do_run(input logic [23:0] key, input bit change_key, output int base);
        int  edges;
        bit  seen;
        init_ram();
        secret_key = key;
        compute_gold(key);
        base = wr_cnt;
        @(negedge clk) start = 1'b1;
        edges = 0;
        seen  = 1'b0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            @(posedge clk);
            edges++;
            #1;
            if (edges == 1) begin
                check("busy_after_start", {31'd0, busy}, 32'd1);
                start = 1'b0;
            end
            if (change_key && edges == 100) secret_key = ~key;
            if (done) seen = 1'b1;
        end
        check("done_seen", {31'd0, seen}, 32'd1);
        check("done_latency", 32'(edges), 32'd1793);
        check("wren_cycles", 32'(wr_cnt - base), 32'd512);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("addr_after_done", {24'd0, address}, 32'd0);
        check_ram("ram_vs_gold");
        secret_key = key;
    endtask

    initial begin
        int base;
        int base2;
        logic acc;
        logic [23:0] rkey;

        n_total  = 0;
        n_pass   = 0;
        wr_cnt   = 0;
        init_req = 1'b0;
        reset    = 1'b0;
        start    = 1'b0;
        secret_key = 24'h000000;

        repeat (2) @(negedge clk);
        check("rst_address", {24'd0, address}, 32'd0);
        check("rst_data", {24'd0, data}, 32'd0);
        check("rst_wren", {31'd0, wren}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        reset = 1'b1;

        // start held low: stays idle, no writes
        init_ram();
        base = wr_cnt;
        acc = 1'b0;
        repeat (20) begin
            @(negedge clk);
            acc = acc | wren | busy;
        end
        check("idle_no_activity", {31'd0, acc}, 32'd0);
        check("idle_no_writes", 32'(wr_cnt - base), 32'd0);

        // all-zero key: i==j at i=0, then a real swap at i=2
        do_run(24'h000000, 1'b0, base);
        check_wr("k0_w0", base + 0, 8'd0, 8'd0);
        check_wr("k0_w1", base + 1, 8'd0, 8'd0);
        check_wr("k0_w2", base + 2, 8'd1, 8'd1);
        check_wr("k0_w3", base + 3, 8'd1, 8'd1);
        check_wr("k0_w4", base + 4, 8'd2, 8'd3);
        check_wr("k0_w5", base + 5, 8'd3, 8'd2);

        // after done, start toggling does nothing
        base2 = wr_cnt;
        repeat (20) @(negedge clk) start = ~start;
        start = 1'b0;
        @(negedge clk);
        check("post_done_no_writes", 32'(wr_cnt - base2), 32'd0);
        check("post_done_done", {31'd0, done}, 32'd1);
        check("post_done_busy", {31'd0, busy}, 32'd0);

        pulse_reset();
        do_run(24'h010203, 1'b0, base);
        check_wr("k123_w0", base + 0, 8'd0, 8'd1);
        check_wr("k123_w1", base + 1, 8'd1, 8'd0);

        for (int r = 0; r < 2; r++) begin
            pulse_reset();
            rkey = 24'($urandom);
            do_run(rkey, 1'b0, base);
        end

        // asynchronous reset in cycle 500 of a run
        pulse_reset();
        init_ram();
        rkey = 24'($urandom);
        secret_key = rkey;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (498) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_address", {24'd0, address}, 32'd0);
        check("abort_data", {24'd0, data}, 32'd0);
        check("abort_wren", {31'd0, wren}, 32'd0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk) reset = 1'b1;
        base2 = wr_cnt;
        repeat (10) @(negedge clk);
        check("abort_idle_no_writes", 32'(wr_cnt - base2), 32'd0);
        check("abort_idle_busy", {31'd0, busy}, 32'd0);
        do_run(rkey, 1'b0, base);

`ifdef KSA_KEY_LATCH_EN
        pulse_reset();
        rkey = 24'($urandom);
        do_run(rkey, 1'b1, base);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
